// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file: default depth, clear/ready FSM
// state encoding and the opcode constants used by the surrounding core.
package reg_file_pkg;

   localparam int unsigned RF_DEPTH_DEFAULT = 32;
   localparam int unsigned RF_WIDTH         = 32;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;

endpackage : reg_file_pkg

// File: rtl/rf_clear_ctrl.sv
// Post-reset clear sequencer: walks every register index once, writing zero,
// then parks in READY until the next reset.
module rf_clear_ctrl
   import reg_file_pkg::*;
#(
   parameter  int unsigned DEPTH = RF_DEPTH_DEFAULT,
   localparam int unsigned IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   output logic [IW-1:0] clr_idx,
   output logic          clr_en_c,
   output logic          rf_ready
);

   rf_state_e     state_q;
   rf_state_e     state_d;
   logic [IW-1:0] cnt_q;
   logic [IW-1:0] cnt_d;
   logic          ready_d;

   // State, counter and ready flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= CLEAR;
         cnt_q    <= '0;
         rf_ready <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rf_ready <= ready_d;
      end
   end

   // Next-state logic: one clear write per cycle, READY after the last index
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = rf_ready;
      clr_en_c = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_en_c = 1'b1;
            cnt_d    = cnt_q + IW'(1);
            if (cnt_q == IW'(DEPTH - 1)) begin
               state_d = READY;
               ready_d = 1'b1;
               cnt_d   = '0;
            end
         end
         READY: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
         end
      endcase
   end

   assign clr_idx = cnt_q;

endmodule : rf_clear_ctrl

// File: rtl/reg_file.sv
// Two-read, one-write 32-bit register file with hardwired-zero index 0 and a
// self-clearing startup sequence. Byte addresses are accepted; the low two
// bits are ignored. Optional macro RF_BYPASS_EN forwards same-cycle write data
// to a colliding read; without it a colliding read returns the old value.
module reg_file
   import reg_file_pkg::*;
#(
   parameter  int unsigned RF_DEPTH = RF_DEPTH_DEFAULT,
   localparam int unsigned AW       = $clog2(RF_DEPTH << 2)
) (
   input  logic          clk_100MHz,
   input  logic          reset,
   input  logic [AW-1:0] writeAddr_RF_WB,
   input  logic [31:0]   writeData_RF_WB,
   input  logic          writeEn_RF_WB,
   input  logic [AW-1:0] readAddr1_RF,
   input  logic [AW-1:0] readAddr2_RF,
   input  logic          readEn_RF,
   output logic [31:0]   readData1_RF,
   output logic [31:0]   readData2_RF,
   output logic          rf_ready
);

   localparam int unsigned IW = AW - 2;

   logic [RF_WIDTH-1:0] mem [RF_DEPTH];

   logic [IW-1:0]       wr_idx;
   logic [IW-1:0]       rd1_idx;
   logic [IW-1:0]       rd2_idx;
   logic [IW-1:0]       clr_idx;
   logic                clr_en_c;
   logic                wr_acc_c;
   logic [RF_WIDTH-1:0] rd1_c;
   logic [RF_WIDTH-1:0] rd2_c;
   logic                unused_addr_lsbs;

   assign wr_idx  = writeAddr_RF_WB[AW-1:2];
   assign rd1_idx = readAddr1_RF[AW-1:2];
   assign rd2_idx = readAddr2_RF[AW-1:2];

   // Byte-offset bits carry no meaning for word registers
   assign unused_addr_lsbs = ^{writeAddr_RF_WB[1:0], readAddr1_RF[1:0],
                               readAddr2_RF[1:0]};

   rf_clear_ctrl #(
      .DEPTH (RF_DEPTH)
   ) u_clear_ctrl (
      .clk      (clk_100MHz),
      .reset    (reset),
      .clr_idx  (clr_idx),
      .clr_en_c (clr_en_c),
      .rf_ready (rf_ready)
   );

   // A write is taken only once cleared, outside reset, and never to index 0
   assign wr_acc_c = writeEn_RF_WB && rf_ready && !reset && (wr_idx != '0);

   // Storage update: clear sequence has priority; no reset on the array itself
   always_ff @(posedge clk_100MHz) begin
      if (clr_en_c) begin
         mem[clr_idx] <= '0;
      end else if (wr_acc_c) begin
         mem[wr_idx] <= writeData_RF_WB;
      end
   end

   // Read data selection for both ports (zero while clearing or for index 0)
   always_comb begin
      rd1_c = '0;
      rd2_c = '0;
      if (rf_ready) begin
         if (rd1_idx != '0) begin
            rd1_c = mem[rd1_idx];
`ifdef RF_BYPASS_EN
            if (wr_acc_c && (wr_idx == rd1_idx)) begin
               rd1_c = writeData_RF_WB;
            end
`endif
         end
         if (rd2_idx != '0) begin
            rd2_c = mem[rd2_idx];
`ifdef RF_BYPASS_EN
            if (wr_acc_c && (wr_idx == rd2_idx)) begin
               rd2_c = writeData_RF_WB;
            end
`endif
         end
      end
   end

   // Registered read ports; values hold while readEn_RF is low
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         readData1_RF <= '0;
         readData2_RF <= '0;
      end else if (readEn_RF) begin
         readData1_RF <= rd1_c;
         readData2_RF <= rd2_c;
      end
   end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default depth 32, 7-bit addresses).
// Build with RF_BYPASS_EN defined to check the forwarding variant.
module tb_reg_file;

   localparam int unsigned AW = 7;

   logic          clk_100MHz;
   logic          reset;
   logic [AW-1:0] writeAddr_RF_WB;
   logic [31:0]   writeData_RF_WB;
   logic          writeEn_RF_WB;
   logic [AW-1:0] readAddr1_RF;
   logic [AW-1:0] readAddr2_RF;
   logic          readEn_RF;
   logic [31:0]   readData1_RF;
   logic [31:0]   readData2_RF;
   logic          rf_ready;

   int vectors;
   int miscompares;

   reg_file #(
      .RF_DEPTH (32)
   ) dut (
      .clk_100MHz      (clk_100MHz),
      .reset           (reset),
      .writeAddr_RF_WB (writeAddr_RF_WB),
      .writeData_RF_WB (writeData_RF_WB),
      .writeEn_RF_WB   (writeEn_RF_WB),
      .readAddr1_RF    (readAddr1_RF),
      .readAddr2_RF    (readAddr2_RF),
      .readEn_RF       (readEn_RF),
      .readData1_RF    (readData1_RF),
      .readData2_RF    (readData2_RF),
      .rf_ready        (rf_ready)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   // Advance one rising edge and settle 1 time unit past it
   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data);
      writeAddr_RF_WB = addr;
      writeData_RF_WB = data;
      writeEn_RF_WB   = 1'b1;
      tick();
      writeEn_RF_WB   = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      readAddr1_RF = a1;
      readAddr2_RF = a2;
      readEn_RF    = 1'b1;
      tick();
      readEn_RF    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vectors++;
      if (rf_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 0", rf_ready);
      end
      vectors++;
      if (readData1_RF !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_rd1: got %h expected 00000000", readData1_RF);
      end
      vectors++;
      if (readData2_RF !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_rd2: got %h expected 00000000", readData2_RF);
      end
      // Release and count the clear sequence, reading while it runs
      reset        = 1'b0;
      readEn_RF    = 1'b1;
      readAddr1_RF = 7'h04;
      readAddr2_RF = 7'h7C;
      for (int k = 1; k <= 32; k++) begin
         tick();
         vectors++;
         if (rf_ready !== (k == 32)) begin
            miscompares++;
            $display("FAIL clear_ready_cycle%0d: got %b expected %b", k, rf_ready, (k == 32));
         end
         vectors++;
         if (readData1_RF !== 32'h0 || readData2_RF !== 32'h0) begin
            miscompares++;
            $display("FAIL clear_read_cycle%0d: got %h/%h expected 0/0", k, readData1_RF, readData2_RF);
         end
      end
      readEn_RF = 1'b0;
      for (int i = 1; i < 32; i++) begin
         do_read(7'(i * 4), 7'(i * 4 + 3));
         vectors++;
         if (readData1_RF !== 32'h0 || readData2_RF !== 32'h0) begin
            miscompares++;
            $display("FAIL cleared_idx%0d: got %h/%h expected 0/0", i, readData1_RF, readData2_RF);
         end
      end
   endtask

   task automatic test_write_read();
      do_write(7'h14, 32'hDEADBEEF);
      do_read(7'h16, 7'h15);
      vectors++;
      if (readData1_RF !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL wr_rd_misaligned_p1: got %h expected deadbeef", readData1_RF);
      end
      vectors++;
      if (readData2_RF !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL wr_rd_misaligned_p2: got %h expected deadbeef", readData2_RF);
      end
      do_write(7'h0C, 32'hCAFEF00D);
      do_read(7'h0C, 7'h14);
      vectors++;
      if (readData1_RF !== 32'hCAFEF00D || readData2_RF !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL two_port_read: got %h/%h expected cafef00d/deadbeef", readData1_RF, readData2_RF);
      end
   endtask

   task automatic test_hold();
      readAddr1_RF = 7'h00;
      readAddr2_RF = 7'h08;
      readEn_RF    = 1'b0;
      tick();
      tick();
      vectors++;
      if (readData1_RF !== 32'hCAFEF00D || readData2_RF !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL read_hold: got %h/%h expected cafef00d/deadbeef", readData1_RF, readData2_RF);
      end
   endtask

   task automatic test_index0();
      do_write(7'h00, 32'h12345678);
      do_read(7'h00, 7'h03);
      vectors++;
      if (readData1_RF !== 32'h0 || readData2_RF !== 32'h0) begin
         miscompares++;
         $display("FAIL index0_read: got %h/%h expected 0/0", readData1_RF, readData2_RF);
      end
   endtask

   task automatic test_collision();
      logic [31:0] exp_rd2;
`ifdef RF_BYPASS_EN
      exp_rd2 = 32'hA5A5A5A5;
`else
      exp_rd2 = 32'h00000011;
`endif
      do_write(7'h08, 32'h00000011);
      writeAddr_RF_WB = 7'h08;
      writeData_RF_WB = 32'hA5A5A5A5;
      writeEn_RF_WB   = 1'b1;
      readAddr1_RF    = 7'h14;
      readAddr2_RF    = 7'h08;
      readEn_RF       = 1'b1;
      tick();
      writeEn_RF_WB   = 1'b0;
      readEn_RF       = 1'b0;
      vectors++;
      if (readData2_RF !== exp_rd2) begin
         miscompares++;
         $display("FAIL collision_p2: got %h expected %h", readData2_RF, exp_rd2);
      end
      vectors++;
      if (readData1_RF !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL collision_p1_other: got %h expected deadbeef", readData1_RF);
      end
      do_read(7'h08, 7'h0B);
      vectors++;
      if (readData1_RF !== 32'hA5A5A5A5 || readData2_RF !== 32'hA5A5A5A5) begin
         miscompares++;
         $display("FAIL collision_after: got %h/%h expected a5a5a5a5/a5a5a5a5", readData1_RF, readData2_RF);
      end
      // Write to index 0 colliding with a read of index 0 still yields zero
      writeAddr_RF_WB = 7'h01;
      writeData_RF_WB = 32'h77777777;
      writeEn_RF_WB   = 1'b1;
      readAddr1_RF    = 7'h00;
      readAddr2_RF    = 7'h02;
      readEn_RF       = 1'b1;
      tick();
      writeEn_RF_WB   = 1'b0;
      readEn_RF       = 1'b0;
      vectors++;
      if (readData1_RF !== 32'h0 || readData2_RF !== 32'h0) begin
         miscompares++;
         $display("FAIL collision_index0: got %h/%h expected 0/0", readData1_RF, readData2_RF);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         writeAddr_RF_WB = 7'(i * 4 + 64);
         writeData_RF_WB = 32'h100 + 32'(i);
         writeEn_RF_WB   = 1'b1;
         tick();
      end
      writeEn_RF_WB = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         do_read(7'(i * 4 + 64), 7'((4 - i) * 4 + 64));
         vectors++;
         if (readData1_RF !== 32'h100 + 32'(i) || readData2_RF !== 32'h100 + 32'(4 - i)) begin
            miscompares++;
            $display("FAIL b2b_read%0d: got %h/%h expected %h/%h", i, readData1_RF, readData2_RF,
                     32'h100 + 32'(i), 32'h100 + 32'(4 - i));
         end
      end
   endtask

   task automatic test_clear_write();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      writeAddr_RF_WB = 7'h04;
      writeData_RF_WB = 32'hFFFFFFFF;
      writeEn_RF_WB   = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
      end
      writeEn_RF_WB = 1'b0;
      vectors++;
      if (rf_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_write_ready: got %b expected 1", rf_ready);
      end
      do_read(7'h04, 7'h14);
      vectors++;
      if (readData1_RF !== 32'h0 || readData2_RF !== 32'h0) begin
         miscompares++;
         $display("FAIL clear_write_discard: got %h/%h expected 0/0", readData1_RF, readData2_RF);
      end
   endtask

   task automatic test_reset_midclear();
      do_write(7'h1C, 32'h55AA55AA);
      do_write(7'h7C, 32'h0BADCAFE);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
      end
      vectors++;
      if (rf_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midclear_ready: got %b expected 0", rf_ready);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         vectors++;
         if (rf_ready !== (k == 32)) begin
            miscompares++;
            $display("FAIL restart_ready_cycle%0d: got %b expected %b", k, rf_ready, (k == 32));
         end
      end
      for (int i = 0; i < 32; i++) begin
         do_read(7'(i * 4), 7'((31 - i) * 4 + 1));
         vectors++;
         if (readData1_RF !== 32'h0 || readData2_RF !== 32'h0) begin
            miscompares++;
            $display("FAIL restart_cleared_idx%0d: got %h/%h expected 0/0", i, readData1_RF, readData2_RF);
         end
      end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      reset           = 1'b1;
      writeAddr_RF_WB = '0;
      writeData_RF_WB = '0;
      writeEn_RF_WB   = 1'b0;
      readAddr1_RF    = '0;
      readAddr2_RF    = '0;
      readEn_RF       = 1'b0;
      test_reset();
      test_write_read();
      test_hold();
      test_index0();
      test_collision();
      test_back_to_back();
      test_clear_write();
      test_reset_midclear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_reg_file
